// File: rtl/vga_sync_tracker_pkg.sv
// Shared 640x480 timing constants, lock-state encoding and small helpers
// for the receive-side VGA sync tracker.
package vga_sync_tracker_pkg;

  // 640x480 @ 60 Hz, 25 MHz pixel clock
  localparam int H_ACTIVE_640 = 640;
  localparam int H_BP_640     = 48;
  localparam int H_TOTAL_800  = 800;
  localparam int V_ACTIVE_480 = 480;
  localparam int V_BP_480     = 33;
  localparam int V_TOTAL_525  = 525;

  localparam int CNT_W = 10;  // h/v counter width
  localparam int DIV_W = 8;   // frame divider and good-frame counter width

  // Both sync lines idle high (sync pulses are active low)
  localparam logic SYNC_IDLE = 1'b1;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'b00,
    ST_ACQUIRE  = 2'b01,
    ST_LOCKED   = 2'b10
  } lock_state_e;

  // True when v lies in the half-open window [lo, hi)
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W:0]   lo,
                                     input logic [CNT_W:0]   hi);
    return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
  endfunction

endpackage

// File: rtl/vga_sync_tracker_sync_edge_detect.sv
// Two-flop sampler for one sync line with single-cycle rise/fall pulses.
// Rise is the deassertion of an active-low sync, fall is its assertion.
module sync_edge_detect
  import vga_sync_tracker_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic rise,
  output logic fall
);

  logic sync_r_q, sync_r_d;
  logic sync_rr_q, sync_rr_d;

  // Shift the pin through the two sample stages
  always_comb begin
    sync_r_d  = sync_in;
    sync_rr_d = sync_r_q;
  end

  // Sample registers come out of reset at the idle (high) level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r_q  <= SYNC_IDLE;
      sync_rr_q <= SYNC_IDLE;
    end else begin
      sync_r_q  <= sync_r_d;
      sync_rr_q <= sync_rr_d;
    end
  end

  assign rise = sync_r_q & ~sync_rr_q;
  assign fall = ~sync_r_q & sync_rr_q;

endmodule

// File: rtl/vga_sync_tracker.sv
// Rebuilds pixel coordinates, line/frame strobes and a lock indication
// from the VGA hsync/vsync pair, and issues a divided game-frame request.
//
// frame_req/frame_ack handshake: frame_req is a level that rises the cycle
// after a qualifying frame_strobe and stays high until frame_ack is sampled
// high; it drops on the following cycle. A request that becomes due while
// frame_req is still high sets the sticky overrun flag (unless frame_ack is
// sampled in that same cycle) and is not queued. frame_ack while frame_req
// is low has no effect.
module vga_sync_tracker
  import vga_sync_tracker_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_640,
  parameter int H_BP        = H_BP_640,
  parameter int H_TOTAL     = H_TOTAL_800,
  parameter int V_ACTIVE    = V_ACTIVE_480,
  parameter int V_BP        = V_BP_480,
  parameter int V_TOTAL     = V_TOTAL_525,
  parameter int LOCK_FRAMES = 2,
  parameter int FRAME_DIV   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hsync_n,
  input  logic             vsync_n,
  input  logic             frame_ack,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             line_strobe,
  output logic             frame_strobe,
  output logic             locked,
  output logic             frame_req,
  output logic             overrun,
  output logic             timing_error,
  output logic [1:0]       dbg_lock_state
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BP_W   = CNT_W'(H_BP);
  localparam logic [CNT_W-1:0] V_BP_W   = CNT_W'(V_BP);
  localparam logic [CNT_W:0]   H_LO     = (CNT_W+1)'(H_BP);
  localparam logic [CNT_W:0]   H_HI     = (CNT_W+1)'(H_BP + H_ACTIVE);
  localparam logic [CNT_W:0]   V_LO     = (CNT_W+1)'(V_BP);
  localparam logic [CNT_W:0]   V_HI     = (CNT_W+1)'(V_BP + V_ACTIVE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [DIV_W-1:0] LOCK_N   = DIV_W'(LOCK_FRAMES);

  logic hs_rise, hs_fall, vs_rise, vs_fall;

  sync_edge_detect u_hsync_edge (
    .clk     (clk),
    .reset   (reset),
    .sync_in (hsync_n),
    .rise    (hs_rise),
    .fall    (hs_fall)
  );

  sync_edge_detect u_vsync_edge (
    .clk     (clk),
    .reset   (reset),
    .sync_in (vsync_n),
    .rise    (vs_rise),
    .fall    (vs_fall)
  );

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_seen_q, h_seen_d;
  logic             v_seen_q, v_seen_d;
  logic             frame_bad_q, frame_bad_d;
  logic             line_strobe_q, line_strobe_d;
  logic             frame_strobe_q, frame_strobe_d;
  logic             timing_error_q, timing_error_d;
  lock_state_e      state_q, state_d;
  logic [DIV_W-1:0] good_cnt_q, good_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             frame_req_q, frame_req_d;
  logic             overrun_q, overrun_d;

  logic h_err, v_err, frame_good, req_due, locked_w;

  assign locked_w = (state_q == ST_LOCKED);

  // Counters, malformed line/frame detection and strobe sources.
  // A vsync rise wins over a coincident hsync rise for v_cnt.
  always_comb begin
    h_err      = hs_rise & h_seen_q & (h_cnt_q != H_LAST);
    v_err      = vs_rise & v_seen_q & (v_cnt_q != V_LAST);
    frame_good = (v_cnt_q == V_LAST) & ~frame_bad_q & ~h_err;

    if (hs_rise)                h_cnt_d = '0;
    else if (h_cnt_q != CNT_MAX) h_cnt_d = h_cnt_q + CNT_W'(1);
    else                        h_cnt_d = h_cnt_q;

    if (vs_rise)                            v_cnt_d = '0;
    else if (hs_rise && v_cnt_q != CNT_MAX) v_cnt_d = v_cnt_q + CNT_W'(1);
    else                                    v_cnt_d = v_cnt_q;

    h_seen_d       = h_seen_q | hs_rise;
    v_seen_d       = v_seen_q | vs_rise;
    frame_bad_d    = vs_rise ? 1'b0 : (frame_bad_q | h_err);
    line_strobe_d  = hs_rise;
    frame_strobe_d = vs_fall;
    timing_error_d = h_err | v_err;
  end

  // Lock FSM, frame divider and request handshake
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    div_d       = div_q;
    req_due     = 1'b0;
    frame_req_d = frame_req_q;
    overrun_d   = overrun_q;

    case (state_q)
      ST_UNLOCKED: begin
        if (vs_rise) begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = '0;
        end
      end
      ST_ACQUIRE: begin
        if (vs_rise) begin
          if (!frame_good) begin
            good_cnt_d = '0;
          end else if (good_cnt_q + DIV_W'(1) >= LOCK_N) begin
            state_d    = ST_LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + DIV_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (timing_error_q) state_d = ST_UNLOCKED;
      end
      default: state_d = ST_UNLOCKED;
    endcase

    if (!locked_w) begin
      div_d = '0;
    end else if (frame_strobe_q) begin
      if (div_q == DIV_LAST) begin
        div_d   = '0;
        req_due = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    if (req_due) begin
      frame_req_d = 1'b1;
      if (frame_req_q && !frame_ack) overrun_d = 1'b1;
    end else if (frame_ack) begin
      frame_req_d = 1'b0;
    end
  end

  // All tracker state; reset drops any pending request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      h_seen_q       <= 1'b0;
      v_seen_q       <= 1'b0;
      frame_bad_q    <= 1'b0;
      line_strobe_q  <= 1'b0;
      frame_strobe_q <= 1'b0;
      timing_error_q <= 1'b0;
      state_q        <= ST_UNLOCKED;
      good_cnt_q     <= '0;
      div_q          <= '0;
      frame_req_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      h_seen_q       <= h_seen_d;
      v_seen_q       <= v_seen_d;
      frame_bad_q    <= frame_bad_d;
      line_strobe_q  <= line_strobe_d;
      frame_strobe_q <= frame_strobe_d;
      timing_error_q <= timing_error_d;
      state_q        <= state_d;
      good_cnt_q     <= good_cnt_d;
      div_q          <= div_d;
      frame_req_q    <= frame_req_d;
      overrun_q      <= overrun_d;
    end
  end

  // Visible-region decode straight off the registered counters
  always_comb begin
    active = locked_w & in_window(h_cnt_q, H_LO, H_HI) & in_window(v_cnt_q, V_LO, V_HI);
    x      = active ? (h_cnt_q - H_BP_W) : '0;
    y      = active ? (v_cnt_q - V_BP_W) : '0;
  end

  assign line_strobe    = line_strobe_q;
  assign frame_strobe   = frame_strobe_q;
  assign locked         = locked_w;
  assign frame_req      = frame_req_q;
  assign overrun        = overrun_q;
  assign timing_error   = timing_error_q;
  assign dbg_lock_state = state_q;

  // Falling edges are sampled but only the deassertion of hsync matters here
  logic unused_edges;
  assign unused_edges = hs_fall;

endmodule

// File: tb/tb_vga_sync_tracker.sv
// Bench for vga_sync_tracker with a shrunken 16x10 raster (8x4 visible).
// A driver walks frames/lines/pixels and pushes expected pixel coordinates
// and expected state events; a monitor pops and compares as the DUT shows them.
module tb_vga_sync_tracker;

  localparam int H_ACTIVE    = 8;
  localparam int H_BP        = 2;
  localparam int H_TOTAL     = 16;
  localparam int V_ACTIVE    = 4;
  localparam int V_BP        = 2;
  localparam int V_TOTAL     = 10;
  localparam int LOCK_FRAMES = 2;
  localparam int FRAME_DIV   = 4;
  localparam int HS_W        = 3;   // hsync low clocks at end of line
  localparam int VS_W        = 2;   // vsync low lines at end of frame
  localparam int N_FRAMES    = 28;

  localparam logic [2:0] K_TE        = 3'd1;
  localparam logic [2:0] K_LOCK_RISE = 3'd2;
  localparam logic [2:0] K_LOCK_FALL = 3'd3;
  localparam logic [2:0] K_REQ_RISE  = 3'd4;
  localparam logic [2:0] K_REQ_FALL  = 3'd5;
  localparam logic [2:0] K_OV_RISE   = 3'd6;
  localparam logic [2:0] K_OV_FALL   = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hsync_n = 1'b1;
  logic vsync_n = 1'b1;
  logic frame_ack = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] x, y;
  logic       active, line_strobe, frame_strobe, locked;
  logic       frame_req, overrun, timing_error;
  logic [1:0] dbg_lock_state;

  vga_sync_tracker #(
    .H_ACTIVE    (H_ACTIVE),
    .H_BP        (H_BP),
    .H_TOTAL     (H_TOTAL),
    .V_ACTIVE    (V_ACTIVE),
    .V_BP        (V_BP),
    .V_TOTAL     (V_TOTAL),
    .LOCK_FRAMES (LOCK_FRAMES),
    .FRAME_DIV   (FRAME_DIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hsync_n        (hsync_n),
    .vsync_n        (vsync_n),
    .frame_ack      (frame_ack),
    .x              (x),
    .y              (y),
    .active         (active),
    .line_strobe    (line_strobe),
    .frame_strobe   (frame_strobe),
    .locked         (locked),
    .frame_req      (frame_req),
    .overrun        (overrun),
    .timing_error   (timing_error),
    .dbg_lock_state (dbg_lock_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [19:0] pix_q[$];   // {x, y}
  logic [18:0] exp_q[$];   // {frame, line, kind}
  int cur_frame = 0;
  int cur_ln = 0;
  int exp_lines = 0, exp_frames = 0;
  int got_lines = 0, got_frames = 0;

  task automatic report(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_zero(input string name);
    logic [26:0] got;
    got = {x, y, active, line_strobe, frame_strobe, locked, frame_req, overrun, timing_error};
    report(name, {5'd0, got}, 32'd0);
  endtask

  task automatic push_ev(input int f, input int ln, input logic [2:0] k);
    exp_q.push_back({8'(f), 8'(ln), k});
  endtask

  task automatic check_event(input logic [2:0] k);
    logic [18:0] got, exp;
    got = {8'(cur_frame), 8'(cur_ln), k};
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL event_unexpected: got 0x%0h expected none", got);
    end else begin
      exp = exp_q.pop_front();
      report("event", {13'd0, got}, {13'd0, exp});
    end
  endtask

  // Frames in which the tracker is expected to be locked over the visible rows
  function automatic bit pix_frame(input int f);
    return (f >= 3 && f <= 16) || (f >= 19 && f <= 22) || (f >= 26);
  endfunction

  // ---------------- driver ----------------
  task automatic drive_pixel(input int f, input int ln, input int px, input int len);
    logic hs, vs;
    @(negedge clk);
    frame_ack = 1'b0;
    cur_frame = f;
    cur_ln    = ln;
    hs = (px < len - HS_W);
    vs = (ln < V_TOTAL - VS_W);
    if (hs && !hsync_n && !reset) exp_lines++;
    if (!vs && vsync_n && !reset) exp_frames++;
    hsync_n = hs;
    vsync_n = vs;
    if (pix_frame(f) && ln >= V_BP && ln < V_BP + V_ACTIVE && px >= H_BP && px < H_BP + H_ACTIVE)
      pix_q.push_back({10'(px - H_BP), 10'(ln - V_BP)});
  endtask

  initial begin
    #3 check_zero("reset_initial");
    #19 reset = 1'b0;
    for (int f = 0; f < N_FRAMES; f++) begin
      for (int ln = 0; ln < V_TOTAL; ln++) begin
        int len;
        len = (f == 16 && ln == 6) ? H_TOTAL - 1 : H_TOTAL;   // one short line
        for (int px = 0; px < len; px++) begin
          drive_pixel(f, ln, px, len);
          if (px == 0 && ln == 0 && (f == 3 || f == 19 || f == 26)) push_ev(f, 0, K_LOCK_RISE);
          if (px == 0 && ln == 8 && (f == 6 || f == 10 || f == 22)) push_ev(f, 8, K_REQ_RISE);
          if (px == 0 && ln == 8 && f == 14) push_ev(f, 8, K_OV_RISE);
          if (px == 0 && ln == 7 && f == 16) begin
            push_ev(f, 7, K_TE);
            push_ev(f, 7, K_LOCK_FALL);
          end
          if (f == 6 && ln == 8 && px == 13) begin
            frame_ack = 1'b1;
            push_ev(f, 8, K_REQ_FALL);
          end
          if (f == 15 && ln == 0 && px == 5) begin
            frame_ack = 1'b1;
            push_ev(f, 0, K_REQ_FALL);
          end
          if (f == 15 && ln == 3 && px == 5) frame_ack = 1'b1;   // no request pending
          if (f == 23 && ln == 1 && px == 5) begin
            push_ev(f, 1, K_LOCK_FALL);
            push_ev(f, 1, K_REQ_FALL);
            push_ev(f, 1, K_OV_FALL);
            #2 reset = 1'b1;
            #1 check_zero("reset_mid_line");
          end
          if (f == 23 && ln == 1 && px == 8) #2 reset = 1'b0;
        end
      end
    end
    for (int px = 0; px < 6; px++) drive_pixel(N_FRAMES, 0, px, H_TOTAL);
    repeat (3) @(negedge clk);
    #2;
    report("pixel_queue_left", 32'(pix_q.size()), 32'd0);
    report("event_queue_left", 32'(exp_q.size()), 32'd0);
    report("line_strobe_count", 32'(got_lines), 32'(exp_lines));
    report("frame_strobe_count", 32'(got_frames), 32'(exp_frames));
    report("final_state", {30'd0, dbg_lock_state}, 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_lock, prev_req, prev_ov;
    logic [19:0] exp_xy;
    prev_lock = 1'b0;
    prev_req  = 1'b0;
    prev_ov   = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (active) begin
        if (pix_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pixel_unexpected: got x=%0d y=%0d expected none", x, y);
        end else begin
          exp_xy = pix_q.pop_front();
          report("pixel_xy", {12'd0, x, y}, {12'd0, exp_xy});
        end
      end else begin
        report("idle_xy", {12'd0, x, y}, 32'd0);
      end
      if (line_strobe) got_lines++;
      if (frame_strobe) got_frames++;
      if (timing_error) check_event(K_TE);
      if (locked && !prev_lock) check_event(K_LOCK_RISE);
      if (!locked && prev_lock) check_event(K_LOCK_FALL);
      if (frame_req && !prev_req) check_event(K_REQ_RISE);
      if (!frame_req && prev_req) check_event(K_REQ_FALL);
      if (overrun && !prev_ov) check_event(K_OV_RISE);
      if (!overrun && prev_ov) check_event(K_OV_FALL);
      prev_lock = locked;
      prev_req  = frame_req;
      prev_ov   = overrun;
    end
  end

endmodule
